// File: rtl/main_cmd_driver.sv
// rtl/main_cmd_driver.sv - command-queue initiator that drives the main mode unit and returns its result
module main_cmd_driver #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [7:0]       cmd_x,
    input  logic [3:0]       cmd_start_len,
    output logic [1:0]       on,
    output logic [7:0]       x,
    output logic             start,
    input  logic [7:0]       m_y,
    input  logic [2:0]       m_s,
    input  logic             m_b,
    input  logic [1:0]       m_regime,
    input  logic             m_active,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_y,
    output logic [2:0]       rsp_s,
    output logic             rsp_b,
    output logic             rsp_active,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic [1:0]       rsp_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]       state;
    logic [1:0]       mode_q;
    logic [3:0]       len_q;
    logic [3:0]       cd;
    logic [7:0]       x_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign x         = x_q;

    // Drive outputs decode from the async-reset state so a reset drops them immediately.
    assign on    = (state == S_ISSUE) ? mode_q : 2'd0;
    assign start = (state == S_ISSUE) ? (len_q != 4'd0)
                                      : ((state == S_RUN) && (cd != 4'd0));

    assign cnt_inc     = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign timeout_hit = (32'(cnt_inc) >= 32'(TIMEOUT_CYC)) || (&cnt_inc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mode_q     <= 2'd0;
            len_q      <= 4'd0;
            cd         <= 4'd0;
            x_q        <= 8'd0;
            cnt        <= '0;
            rsp_y      <= 8'd0;
            rsp_s      <= 3'd0;
            rsp_b      <= 1'b0;
            rsp_active <= 1'b0;
            rsp_cycles <= '0;
            rsp_err    <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        mode_q <= cmd_mode;
                        len_q  <= cmd_start_len;
                        if (cmd_mode == 2'd0 || m_regime != 2'd0) begin
                            rsp_y      <= 8'd0;
                            rsp_s      <= 3'd0;
                            rsp_b      <= 1'b0;
                            rsp_active <= 1'b0;
                            rsp_cycles <= '0;
                            rsp_err    <= (cmd_mode == 2'd0) ? 2'd1 : 2'd3;
                            state      <= S_RESP;
                        end else begin
                            x_q   <= cmd_x;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cd    <= (len_q == 4'd0) ? 4'd0 : len_q - 4'd1;
                    cnt   <= CNT_W'(1);
                    state <= S_RUN;
                end
                S_RUN: begin
                    // The burst always completes; regime is only judged once in WAIT.
                    cnt <= cnt_inc;
                    if (cd != 4'd0) begin
                        cd <= cd - 4'd1;
                    end
                    if (cd <= 4'd1) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt_inc;
                    if (m_regime == 2'd0 || timeout_hit) begin
                        rsp_y      <= m_y;
                        rsp_s      <= m_s;
                        rsp_b      <= m_b;
                        rsp_active <= m_active;
                        rsp_cycles <= cnt_inc;
                        rsp_err    <= (m_regime == 2'd0) ? 2'd0 : 2'd2;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_cmd_driver.sv
// tb/tb_main_cmd_driver.sv - scoreboard bench for main_cmd_driver with a hand-driven main stub
module tb_main_cmd_driver;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] s;
        logic       b;
        logic       act;
        logic [7:0] cyc;
        logic [1:0] err;
        logic       ck_cyc;
        logic       ck_dat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       cmd_valid, cmd_valid8;
    logic       cmd_ready, cmd_ready8;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_x;
    logic [3:0] cmd_start_len;
    logic [1:0] on, on8;
    logic [7:0] x, x8;
    logic       start, start8;
    logic [7:0] m_y;
    logic [2:0] m_s;
    logic       m_b;
    logic [1:0] m_regime;
    logic       m_active;
    logic       rsp_valid, rsp_valid8;
    logic       rsp_ready;
    logic [7:0] rsp_y, rsp_y8;
    logic [2:0] rsp_s, rsp_s8;
    logic       rsp_b, rsp_b8;
    logic       rsp_active, rsp_active8;
    logic [7:0] rsp_cycles, rsp_cycles8;
    logic [1:0] rsp_err, rsp_err8;

    exp_t q[$];
    exp_t q8[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    main_cmd_driver dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_x(cmd_x), .cmd_start_len(cmd_start_len),
        .on(on), .x(x), .start(start),
        .m_y(m_y), .m_s(m_s), .m_b(m_b), .m_regime(m_regime), .m_active(m_active),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_s(rsp_s),
        .rsp_b(rsp_b), .rsp_active(rsp_active), .rsp_cycles(rsp_cycles), .rsp_err(rsp_err)
    );

    main_cmd_driver #(.TIMEOUT_CYC(8)) dut8 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8), .cmd_mode(cmd_mode),
        .cmd_x(cmd_x), .cmd_start_len(cmd_start_len),
        .on(on8), .x(x8), .start(start8),
        .m_y(m_y), .m_s(m_s), .m_b(m_b), .m_regime(m_regime), .m_active(m_active),
        .rsp_valid(rsp_valid8), .rsp_ready(1'b1), .rsp_y(rsp_y8), .rsp_s(rsp_s8),
        .rsp_b(rsp_b8), .rsp_active(rsp_active8), .rsp_cycles(rsp_cycles8), .rsp_err(rsp_err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_rsp(input string tag, input exp_t e, input logic [7:0] y, input logic [2:0] s,
                           input logic b, input logic a, input logic [7:0] c, input logic [1:0] er);
        chk({tag, "_err"}, 32'(er), 32'(e.err));
        if (e.ck_cyc) chk({tag, "_cycles"}, 32'(c), 32'(e.cyc));
        if (e.ck_dat) begin
            chk({tag, "_y"}, 32'(y), 32'(e.y));
            chk({tag, "_s"}, 32'(s), 32'(e.s));
            chk({tag, "_b"}, 32'(b), 32'(e.b));
            chk({tag, "_active"}, 32'(a), 32'(e.act));
        end
    endtask

    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
            end else begin
                cmp_rsp("rsp", q.pop_front(), rsp_y, rsp_s, rsp_b, rsp_active, rsp_cycles, rsp_err);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && rsp_valid8) begin
            if (q8.size() == 0) begin
                chk("unexpected_rsp8", 32'(rsp_valid8), 32'(0));
            end else begin
                cmp_rsp("rsp8", q8.pop_front(), rsp_y8, rsp_s8, rsp_b8, rsp_active8, rsp_cycles8, rsp_err8);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] mode, input logic [7:0] xx, input logic [3:0] len);
        logic acc;
        acc           = 1'b0;
        cmd_mode      = mode;
        cmd_x         = xx;
        cmd_start_len = len;
        cmd_valid     = 1'b1;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = cmd_ready;
            step();
        end
        chk("cmd_accept", 32'(acc), 32'(1));
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && !cmd_ready; k++) step();
        chk("return_idle", 32'(cmd_ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_valid8 = 1'b0; cmd_mode = 2'd0; cmd_x = 8'd0;
        cmd_start_len = 4'd0; m_y = 8'd0; m_s = 3'd0; m_b = 1'b0; m_regime = 2'd0;
        m_active = 1'b0; rsp_ready = 1'b1;
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_on", 32'(on), 32'(0));
        chk("rst_start", 32'(start), 32'(0));
        chk("rst_x", 32'(x), 32'(0));
        chk("rst_rsp_fields", {rsp_y, 5'(rsp_s), 2'(rsp_b), rsp_cycles, 4'(rsp_err), 4'(rsp_active)}, 32'(0));
        step();
        rst = 1'b1;
        step();

        // Load: regime returns to 0 three cycles after ISSUE.
        q.push_back('{y: 8'd3, s: 3'd6, b: 1'b1, act: 1'b0, cyc: 8'd4, err: 2'd0, ck_cyc: 1'b1, ck_dat: 1'b1});
        send_cmd(2'd3, 8'd5, 4'd0);
        chk("load_on_issue", 32'(on), 32'(3));
        chk("load_x_issue", 32'(x), 32'(5));
        chk("load_start_issue", 32'(start), 32'(0));
        m_regime = 2'd3;
        for (int i = 1; i < 3; i++) begin
            step();
            chk("load_on_after", 32'(on), 32'(0));
            chk("load_start_after", 32'(start), 32'(0));
            chk("load_x_hold", 32'(x), 32'(5));
        end
        step();
        m_regime = 2'd0; m_y = 8'd3; m_s = 3'd6; m_b = 1'b1; m_active = 1'b0;
        wait_idle();

        // Count: start burst of 11, regime drops the cycle start is first low.
        q.push_back('{y: 8'h77, s: 3'd2, b: 1'b0, act: 1'b1, cyc: 8'd12, err: 2'd0, ck_cyc: 1'b1, ck_dat: 1'b1});
        send_cmd(2'd2, 8'h9A, 4'd11);
        m_regime = 2'd2;
        for (int i = 0; i < 11; i++) begin
            chk("count_start_high", 32'(start), 32'(1));
            step();
        end
        chk("count_start_low", 32'(start), 32'(0));
        chk("count_x_hold", 32'(x), 32'h9A);
        m_regime = 2'd0; m_y = 8'h77; m_s = 3'd2; m_b = 1'b0; m_active = 1'b1;
        wait_idle();

        // Enumerate with regime stuck: both timeout settings run together.
        m_y = 8'h11; m_s = 3'd1; m_b = 1'b1; m_active = 1'b1;
        q.push_back('{y: 8'h11, s: 3'd1, b: 1'b1, act: 1'b1, cyc: 8'd64, err: 2'd2, ck_cyc: 1'b1, ck_dat: 1'b1});
        q8.push_back('{y: 8'h11, s: 3'd1, b: 1'b1, act: 1'b1, cyc: 8'd8, err: 2'd2, ck_cyc: 1'b1, ck_dat: 1'b1});
        cmd_valid8 = 1'b1;
        send_cmd(2'd1, 8'h22, 4'd0);
        cmd_valid8 = 1'b0;
        chk("enum_on_issue", 32'(on), 32'(1));
        m_regime = 2'd1;
        wait_idle();
        m_regime = 2'd0;
        step();

        // Illegal mode: immediate error, main untouched.
        q.push_back('{y: 8'd0, s: 3'd0, b: 1'b0, act: 1'b0, cyc: 8'd0, err: 2'd1, ck_cyc: 1'b1, ck_dat: 1'b0});
        send_cmd(2'd0, 8'h44, 4'd3);
        chk("illegal_on", 32'(on), 32'(0));
        chk("illegal_start", 32'(start), 32'(0));
        chk("illegal_x_unchanged", 32'(x), 32'h22);
        wait_idle();

        // Busy at issue.
        m_regime = 2'd2;
        q.push_back('{y: 8'd0, s: 3'd0, b: 1'b0, act: 1'b0, cyc: 8'd0, err: 2'd3, ck_cyc: 1'b0, ck_dat: 1'b0});
        send_cmd(2'd3, 8'h55, 4'd1);
        chk("busy_on", 32'(on), 32'(0));
        step();
        chk("busy_on_later", 32'(on), 32'(0));
        wait_idle();
        m_regime = 2'd0;
        step();

        // Backpressure with a second command pending.
        rsp_ready = 1'b0;
        m_y = 8'h5A; m_s = 3'd5; m_b = 1'b1; m_active = 1'b0;
        q.push_back('{y: 8'h5A, s: 3'd5, b: 1'b1, act: 1'b0, cyc: 8'd3, err: 2'd0, ck_cyc: 1'b1, ck_dat: 1'b1});
        send_cmd(2'd3, 8'h10, 4'd2);
        q.push_back('{y: 8'd0, s: 3'd0, b: 1'b0, act: 1'b0, cyc: 8'd0, err: 2'd1, ck_cyc: 1'b1, ck_dat: 1'b0});
        cmd_mode = 2'd0; cmd_x = 8'h01; cmd_start_len = 4'd0; cmd_valid = 1'b1;
        for (int k = 0; k < 50 && !rsp_valid; k++) step();
        m_y = 8'hFF; m_s = 3'd0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_cmd_ready", 32'(cmd_ready), 32'(0));
            chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("bp_rsp_y_stable", 32'(rsp_y), 32'h5A);
            chk("bp_rsp_cycles_stable", 32'(rsp_cycles), 32'(3));
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_ready_after_hs", 32'(cmd_ready), 32'(1));
        chk("bp_valid_after_hs", 32'(rsp_valid), 32'(0));
        step();
        cmd_valid = 1'b0;
        chk("bp_second_accepted", 32'(rsp_valid), 32'(1));
        chk("bp_second_not_ready", 32'(cmd_ready), 32'(0));
        wait_idle();

        // Reset in the middle of a start burst.
        send_cmd(2'd2, 8'h33, 4'd8);
        m_regime = 2'd2;
        step(); step(); step();
        chk("rst_mid_start_high", 32'(start), 32'(1));
        #3;
        rst = 1'b0;
        #1;
        chk("rst_async_on", 32'(on), 32'(0));
        chk("rst_async_start", 32'(start), 32'(0));
        chk("rst_async_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rst_async_rsp_valid", 32'(rsp_valid), 32'(0));
        step();
        m_regime = 2'd0;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("rst_no_rsp", 32'(rsp_valid), 32'(0));

        chk("queue_drained", 32'(q.size()), 32'(0));
        chk("queue8_drained", 32'(q8.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
